// File: rtl/csr_trap_file.sv
// Trap-state CSR slice: mstatus (with sstatus view), exception PC/cause/tval
// registers, medeleg and minstret, with WARL write masking and registered reads.
module csr_trap_file #(
    parameter int                     XLEN          = 64,
    parameter int                     RETIRE_W      = 3,
    parameter logic [63:0]            MSTATUS_WMASK = 64'h0000_0000_007E_79AA,
    parameter logic [63:0]            SSTATUS_MASK  = 64'h8000_0003_000D_E762
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                mstatus_we,
    input  logic                sstatus_we,
    input  logic                mepc_we,
    input  logic                mcause_we,
    input  logic                mtval_we,
    input  logic                sepc_we,
    input  logic                scause_we,
    input  logic                stval_we,
    input  logic                medeleg_we,
    input  logic                minstret_we,

    input  logic [XLEN-1:0]     mstatus_wdata,
    input  logic [XLEN-1:0]     sstatus_wdata,
    input  logic [XLEN-1:0]     mepc_wdata,
    input  logic [XLEN-1:0]     mcause_wdata,
    input  logic [XLEN-1:0]     mtval_wdata,
    input  logic [XLEN-1:0]     sepc_wdata,
    input  logic [XLEN-1:0]     scause_wdata,
    input  logic [XLEN-1:0]     stval_wdata,
    input  logic [XLEN-1:0]     medeleg_wdata,
    input  logic [XLEN-1:0]     minstret_wdata,

    input  logic [RETIRE_W-1:0] retire_cnt,
    input  logic                mcountinhibit_ir,

    output logic [XLEN-1:0]     mstatus_rdata,
    output logic [XLEN-1:0]     sstatus_rdata,
    output logic [XLEN-1:0]     mepc_rdata,
    output logic [XLEN-1:0]     mcause_rdata,
    output logic [XLEN-1:0]     mtval_rdata,
    output logic [XLEN-1:0]     sepc_rdata,
    output logic [XLEN-1:0]     scause_rdata,
    output logic [XLEN-1:0]     stval_rdata,
    output logic [XLEN-1:0]     medeleg_rdata,
    output logic [XLEN-1:0]     minstret_rdata,
    output logic                wr_conflict
);

    localparam logic [XLEN-1:0] MS_WMASK     = MSTATUS_WMASK[XLEN-1:0];
    localparam logic [XLEN-1:0] SS_MASK      = SSTATUS_MASK[XLEN-1:0];
    localparam logic [XLEN-1:0] SS_WMASK     = MS_WMASK & SS_MASK;
    localparam logic [XLEN-1:0] MEDELEG_MASK = {{(XLEN-16){1'b0}}, 16'hF7FF};
    localparam logic [XLEN-1:0] EPC_MASK     = {{(XLEN-1){1'b1}}, 1'b0};

    logic [XLEN-1:0] mstatus_q,  mstatus_d;
    logic [XLEN-1:0] mepc_q,     mepc_d;
    logic [XLEN-1:0] mcause_q,   mcause_d;
    logic [XLEN-1:0] mtval_q,    mtval_d;
    logic [XLEN-1:0] sepc_q,     sepc_d;
    logic [XLEN-1:0] scause_q,   scause_d;
    logic [XLEN-1:0] stval_q,    stval_d;
    logic [XLEN-1:0] medeleg_q,  medeleg_d;
    logic [XLEN-1:0] minstret_q, minstret_d;
    logic            conflict_q, conflict_d;
    logic [XLEN-1:0] mstatus_view;

    // mstatus wins over sstatus when both strobe; a reserved MPP encoding is ignored.
    always_comb begin
        mstatus_d = mstatus_q;
        if (mstatus_we) begin
            mstatus_d = (mstatus_q & ~MS_WMASK) | (mstatus_wdata & MS_WMASK);
            if (mstatus_wdata[12:11] == 2'b10) begin
                mstatus_d[12:11] = mstatus_q[12:11];
            end
        end else if (sstatus_we) begin
            mstatus_d = (mstatus_q & ~SS_WMASK) | (sstatus_wdata & SS_WMASK);
        end
    end

    always_comb begin
        mepc_d     = mepc_we    ? (mepc_wdata & EPC_MASK)       : mepc_q;
        sepc_d     = sepc_we    ? (sepc_wdata & EPC_MASK)       : sepc_q;
        mcause_d   = mcause_we  ? mcause_wdata                  : mcause_q;
        mtval_d    = mtval_we   ? mtval_wdata                   : mtval_q;
        scause_d   = scause_we  ? scause_wdata                  : scause_q;
        stval_d    = stval_we   ? stval_wdata                   : stval_q;
        medeleg_d  = medeleg_we ? (medeleg_wdata & MEDELEG_MASK) : medeleg_q;
        conflict_d = conflict_q | (mstatus_we & sstatus_we);
    end

    // A software write to minstret takes priority over that cycle's retirements.
    always_comb begin
        minstret_d = minstret_q;
        if (minstret_we) begin
            minstret_d = minstret_wdata;
        end else if (!mcountinhibit_ir) begin
            minstret_d = minstret_q + {{(XLEN-RETIRE_W){1'b0}}, retire_cnt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_q  <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            sepc_q     <= '0;
            scause_q   <= '0;
            stval_q    <= '0;
            medeleg_q  <= '0;
            minstret_q <= '0;
            conflict_q <= 1'b0;
        end else begin
            mstatus_q  <= mstatus_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            sepc_q     <= sepc_d;
            scause_q   <= scause_d;
            stval_q    <= stval_d;
            medeleg_q  <= medeleg_d;
            minstret_q <= minstret_d;
            conflict_q <= conflict_d;
        end
    end

    // SD summarises FS only; SXL/UXL are fixed at 64-bit.
    always_comb begin
        mstatus_view         = mstatus_q;
        mstatus_view[XLEN-1] = (mstatus_q[14:13] == 2'b11);
        mstatus_view[35:32]  = 4'b1010;
    end

    assign mstatus_rdata  = mstatus_view;
    assign sstatus_rdata  = mstatus_view & SS_MASK;
    assign mepc_rdata     = mepc_q;
    assign mcause_rdata   = mcause_q;
    assign mtval_rdata    = mtval_q;
    assign sepc_rdata     = sepc_q;
    assign scause_rdata   = scause_q;
    assign stval_rdata    = stval_q;
    assign medeleg_rdata  = medeleg_q;
    assign minstret_rdata = minstret_q;
    assign wr_conflict    = conflict_q;

endmodule

// File: tb/tb_csr_trap_file.sv
// Directed bench for csr_trap_file: spec-level model checked every cycle on the
// falling edge, plus literal expectations at the points the test plan names.
module tb_csr_trap_file;

    localparam logic [63:0] WMASK = 64'h0000_0000_007E_79AA;
    localparam logic [63:0] SMASK = 64'h8000_0003_000D_E762;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mstatus_we = 0, sstatus_we = 0, mepc_we = 0, mcause_we = 0, mtval_we = 0;
    logic        sepc_we = 0, scause_we = 0, stval_we = 0, medeleg_we = 0, minstret_we = 0;
    logic [63:0] mstatus_wdata = 0, sstatus_wdata = 0, mepc_wdata = 0, mcause_wdata = 0;
    logic [63:0] mtval_wdata = 0, sepc_wdata = 0, scause_wdata = 0, stval_wdata = 0;
    logic [63:0] medeleg_wdata = 0, minstret_wdata = 0;
    logic [2:0]  retire_cnt = 0;
    logic        mcountinhibit_ir = 0;
    logic [63:0] mstatus_rdata, sstatus_rdata, mepc_rdata, mcause_rdata, mtval_rdata;
    logic [63:0] sepc_rdata, scause_rdata, stval_rdata, medeleg_rdata, minstret_rdata;
    logic        wr_conflict;

    int checks = 0;
    int errors = 0;

    csr_trap_file dut (
        .clk(clk), .rst_n(rst_n),
        .mstatus_we(mstatus_we), .sstatus_we(sstatus_we), .mepc_we(mepc_we),
        .mcause_we(mcause_we), .mtval_we(mtval_we), .sepc_we(sepc_we),
        .scause_we(scause_we), .stval_we(stval_we), .medeleg_we(medeleg_we),
        .minstret_we(minstret_we),
        .mstatus_wdata(mstatus_wdata), .sstatus_wdata(sstatus_wdata),
        .mepc_wdata(mepc_wdata), .mcause_wdata(mcause_wdata), .mtval_wdata(mtval_wdata),
        .sepc_wdata(sepc_wdata), .scause_wdata(scause_wdata), .stval_wdata(stval_wdata),
        .medeleg_wdata(medeleg_wdata), .minstret_wdata(minstret_wdata),
        .retire_cnt(retire_cnt), .mcountinhibit_ir(mcountinhibit_ir),
        .mstatus_rdata(mstatus_rdata), .sstatus_rdata(sstatus_rdata),
        .mepc_rdata(mepc_rdata), .mcause_rdata(mcause_rdata), .mtval_rdata(mtval_rdata),
        .sepc_rdata(sepc_rdata), .scause_rdata(scause_rdata), .stval_rdata(stval_rdata),
        .medeleg_rdata(medeleg_rdata), .minstret_rdata(minstret_rdata),
        .wr_conflict(wr_conflict)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Architectural values as software sees them; mstatus kept as the raw
    // writable field contents, decorated with SD/SXL/UXL only when read.
    logic [63:0] m_ms = 0, m_mepc = 0, m_mcause = 0, m_mtval = 0, m_sepc = 0;
    logic [63:0] m_scause = 0, m_stval = 0, m_medeleg = 0, m_minstret = 0;
    logic        m_conflict = 0;

    function automatic logic [63:0] ms_read(input logic [63:0] raw);
        logic [63:0] sd;
        sd = (raw[14] && raw[13]) ? 64'h8000_0000_0000_0000 : 64'h0;
        return raw | sd | 64'h0000_000A_0000_0000;
    endfunction

    function automatic logic [63:0] ms_write(input logic [63:0] old, input logic [63:0] wd);
        logic [63:0] res;
        for (int b = 0; b < 64; b++) res[b] = WMASK[b] ? wd[b] : old[b];
        if (wd[12:11] == 2'b10) res[12:11] = old[12:11];
        return res;
    endfunction

    function automatic logic [63:0] ss_write(input logic [63:0] old, input logic [63:0] wd);
        logic [63:0] res;
        for (int b = 0; b < 64; b++) res[b] = (WMASK[b] && SMASK[b]) ? wd[b] : old[b];
        return res;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ms <= 0; m_mepc <= 0; m_mcause <= 0; m_mtval <= 0; m_sepc <= 0;
            m_scause <= 0; m_stval <= 0; m_medeleg <= 0; m_minstret <= 0;
            m_conflict <= 0;
        end else begin
            if (mstatus_we)      m_ms <= ms_write(m_ms, mstatus_wdata);
            else if (sstatus_we) m_ms <= ss_write(m_ms, sstatus_wdata);
            if (mstatus_we && sstatus_we) m_conflict <= 1;
            if (mepc_we)    m_mepc    <= {mepc_wdata[63:1], 1'b0};
            if (sepc_we)    m_sepc    <= {sepc_wdata[63:1], 1'b0};
            if (mcause_we)  m_mcause  <= mcause_wdata;
            if (mtval_we)   m_mtval   <= mtval_wdata;
            if (scause_we)  m_scause  <= scause_wdata;
            if (stval_we)   m_stval   <= stval_wdata;
            if (medeleg_we) m_medeleg <= {48'h0, medeleg_wdata[15:12], 1'b0, medeleg_wdata[10:0]};
            if (minstret_we)            m_minstret <= minstret_wdata;
            else if (!mcountinhibit_ir) m_minstret <= m_minstret + 64'(retire_cnt);
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        chk("cyc_mstatus",  mstatus_rdata,  ms_read(m_ms));
        chk("cyc_sstatus",  sstatus_rdata,  ms_read(m_ms) & SMASK);
        chk("cyc_mepc",     mepc_rdata,     m_mepc);
        chk("cyc_mcause",   mcause_rdata,   m_mcause);
        chk("cyc_mtval",    mtval_rdata,    m_mtval);
        chk("cyc_sepc",     sepc_rdata,     m_sepc);
        chk("cyc_scause",   scause_rdata,   m_scause);
        chk("cyc_stval",    stval_rdata,    m_stval);
        chk("cyc_medeleg",  medeleg_rdata,  m_medeleg);
        chk("cyc_minstret", minstret_rdata, m_minstret);
        chk("cyc_conflict", {63'h0, wr_conflict}, {63'h0, m_conflict});
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the falling edge; literal checks happen
    // on the falling edge, i.e. one full cycle after the strobes were driven.
    task automatic clear_strobes();
        mstatus_we = 0; sstatus_we = 0; mepc_we = 0; mcause_we = 0; mtval_we = 0;
        sepc_we = 0; scause_we = 0; stval_we = 0; medeleg_we = 0; minstret_we = 0;
        retire_cnt = 0; mcountinhibit_ir = 0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1 clear_strobes();
    endtask

    task automatic wr_minstret(input logic [63:0] v, input logic [2:0] rc);
        minstret_we = 1; minstret_wdata = v; retire_cnt = rc;
        next_cycle();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        clear_strobes();
        repeat (2) next_cycle();
        chk("rst_mstatus",  mstatus_rdata,  64'h0000_000A_0000_0000);
        chk("rst_sstatus",  sstatus_rdata,  64'h0000_0002_0000_0000);
        chk("rst_minstret", minstret_rdata, 64'h0);
        chk("rst_medeleg",  medeleg_rdata,  64'h0);
        chk("rst_conflict", {63'h0, wr_conflict}, 64'h0);
        #1 rst_n = 1;

        // mstatus all-ones: same-cycle read unchanged, next cycle shows masked value
        next_cycle(); #1;
        mstatus_we = 1; mstatus_wdata = ONES;
        #1 chk("ms_same_cycle", mstatus_rdata, 64'h0000_000A_0000_0000);
        next_cycle();
        chk("ms_ones",  mstatus_rdata, 64'h8000_000A_007E_79AA);
        chk("ss_ones",  sstatus_rdata, 64'h8000_0002_000C_6122);
        settle();

        // MPP=3, then reserved MPP encoding with MIE=1
        mstatus_we = 1; mstatus_wdata = 64'h1800;
        next_cycle(); settle();
        mstatus_we = 1; mstatus_wdata = 64'h1008;
        next_cycle();
        chk("mpp_keep", mstatus_rdata, 64'h0000_000A_0000_1808);
        settle();

        // sstatus write alone reaches only the shared writable bits
        mstatus_we = 1; mstatus_wdata = 64'h0;
        next_cycle(); settle();
        sstatus_we = 1; sstatus_wdata = ONES;
        next_cycle();
        chk("ss_write", mstatus_rdata, 64'h8000_000A_000C_6122);
        settle();

        // simultaneous mstatus/sstatus: mstatus wins, conflict goes sticky
        mstatus_we = 1; mstatus_wdata = 64'h0; sstatus_we = 1; sstatus_wdata = ONES;
        next_cycle();
        chk("conf_ms",   mstatus_rdata, 64'h0000_000A_0000_0000);
        chk("conf_flag", {63'h0, wr_conflict}, 64'h1);
        settle();
        repeat (3) next_cycle();
        chk("conf_sticky", {63'h0, wr_conflict}, 64'h1);
        #1;

        // minstret wrap, inhibit, write-over-retire
        wr_minstret(64'hFFFF_FFFF_FFFF_FFFE, 3'd0); settle();
        retire_cnt = 3;
        next_cycle(); chk("ir_wrap", minstret_rdata, 64'h1); settle();
        retire_cnt = 5; mcountinhibit_ir = 1;
        next_cycle(); chk("ir_inhibit", minstret_rdata, 64'h1); settle();
        wr_minstret(64'd100, 3'd7);
        chk("ir_write", minstret_rdata, 64'd100); settle();
        retire_cnt = 7;
        next_cycle(); chk("ir_add7", minstret_rdata, 64'd107); settle();

        // independent CSRs in one cycle
        mepc_we = 1;    mepc_wdata = 64'h8000_0003;
        sepc_we = 1;    sepc_wdata = 64'hFFFF_0000_1234_5671;
        medeleg_we = 1; medeleg_wdata = ONES;
        mcause_we = 1;  mcause_wdata = 64'h8000_0000_0000_000B;
        mtval_we = 1;   mtval_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        scause_we = 1;  scause_wdata = 64'h0000_0000_0000_000D;
        stval_we = 1;   stval_wdata = ONES;
        retire_cnt = 2;
        next_cycle();
        chk("mepc",    mepc_rdata,    64'h8000_0002);
        chk("sepc",    sepc_rdata,    64'hFFFF_0000_1234_5670);
        chk("medeleg", medeleg_rdata, 64'h0000_0000_0000_F7FF);
        chk("mcause",  mcause_rdata,  64'h8000_0000_0000_000B);
        chk("stval",   stval_rdata,   ONES);
        chk("ir_add2", minstret_rdata, 64'd109);
        settle();

        // a few mixed cycles driven from the model's point of view
        for (int i = 0; i < 20; i++) begin
            mstatus_we = ($urandom_range(0, 3) == 0);
            sstatus_we = ($urandom_range(0, 3) == 0) && !mstatus_we;
            mstatus_wdata = {$urandom, $urandom};
            sstatus_wdata = {$urandom, $urandom};
            mepc_we = $urandom_range(0, 1); mepc_wdata = {$urandom, $urandom};
            medeleg_we = $urandom_range(0, 1); medeleg_wdata = {$urandom, $urandom};
            minstret_we = ($urandom_range(0, 7) == 0); minstret_wdata = {$urandom, $urandom};
            retire_cnt = 3'($urandom_range(0, 7));
            mcountinhibit_ir = ($urandom_range(0, 3) == 0);
            next_cycle(); settle();
        end

        // reset landing on top of a pending write: nothing completes
        mstatus_we = 1; mstatus_wdata = ONES; minstret_we = 1; minstret_wdata = 64'd55;
        #2 rst_n = 0;
        next_cycle();
        chk("rst2_mstatus",  mstatus_rdata,  64'h0000_000A_0000_0000);
        chk("rst2_minstret", minstret_rdata, 64'h0);
        chk("rst2_conflict", {63'h0, wr_conflict}, 64'h0);
        chk("rst2_mepc",     mepc_rdata,     64'h0);
        #1 clear_strobes(); rst_n = 1;
        repeat (2) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
